control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 162 ++++++++++++++++
 tb/tb_control_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Instruction-sequencing FSM: fetches an opcode, decodes it into datapath selects and
// strobes for one EXEC cycle, and stretches data-memory writes until the memory accepts them.
module control_sequencer #(
    parameter int OPCODE_W  = 6,
    parameter int NUM_PREG  = 9,
    parameter int NUM_FLAGS = 2,
    parameter int BSEL_W    = 4,
    parameter int CSEL_W    = 8,
    parameter int PSEL_W    = 4,
    localparam int FSEL_W   = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 instr_valid,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [NUM_FLAGS-1:0] flags,
    input  logic                 mem_ready,
    output logic                 data_write_en,
    output logic                 p_reg_write_en,
    output logic                 pc_en,
    output logic                 stop_flag,
    output logic                 flag_wr_en,
    output logic [BSEL_W-1:0]    b_bus_select,
    output logic [CSEL_W-1:0]    c_bus_select,
    output logic [PSEL_W-1:0]    p_reg_select,
    output logic [2:0]           alu_select,
    output logic [FSEL_W-1:0]    flag_reg_select,
    output logic                 busy,
    output logic                 illegal_op
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEMWAIT, HALT} state_t;

    state_t                state;
    logic [OPCODE_W-1:0]   ir;
    logic [NUM_FLAGS-1:0]  fr;

    logic [5:0] op;
    logic       hi_bits;
    logic       legal, ldp, is_str, is_stop, fwe, fsel;
    logic [3:0] pn;
    logic [2:0] b, alu;
    logic [7:0] c;

    assign op      = ir[5:0];
    assign hi_bits = |(ir >> 6);

    // Decode of the latched instruction; illegal encodings collapse to NOOP.
    always_comb begin
        legal   = 1'b1;
        ldp     = 1'b0;
        pn      = 4'd0;
        is_str  = 1'b0;
        is_stop = 1'b0;
        fwe     = 1'b0;
        fsel    = 1'b0;
        b       = 3'd0;
        c       = 8'h00;
        alu     = 3'd0;
        case (op)
            6'h01, 6'h17: ;
            6'h02, 6'h03, 6'h04, 6'h05: begin ldp = 1'b1; pn = 4'(op - 6'h01); end
            6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: begin ldp = 1'b1; pn = 4'(op - 6'h14); end
            6'h06: begin b = 3'd1; c = 8'h02; alu = 3'd1; end
            6'h07: is_str = 1'b1;
            6'h08: begin b = 3'd4; c = 8'h01; alu = 3'd1; end
            6'h09: c = 8'h10;
            6'h0A: begin c = 8'h01; alu = 3'd6; end
            6'h0B: begin c = 8'h01; alu = 3'd7; end
            6'h0C: begin b = 3'd7; c = 8'h80; alu = 3'd5; end
            6'h0D: begin b = 3'd7; c = 8'h40; alu = 3'd1; end
            6'h0E: begin c = 8'h01; alu = 3'd2; end
            6'h0F: begin c = 8'h08; alu = 3'd2; end
            6'h10: begin c = 8'h04; alu = 3'd2; end
            6'h11: begin b = 3'd5; c = 8'h08; alu = 3'd5; end
            6'h12: begin b = 3'd6; c = 8'h04; alu = 3'd5; end
            6'h13: if (fr[0]) begin c = 8'h20; alu = 3'd1; end
            6'h14: if (fr[1]) begin c = 8'h20; alu = 3'd1; end
            6'h15: c = 8'h40;
            6'h16: begin b = 3'd4; c = 8'h40; alu = 3'd1; end
            6'h18: is_stop = 1'b1;
            6'h1E: fwe = 1'b1;
            6'h1F: begin fwe = 1'b1; fsel = 1'b1; end
            default: legal = 1'b0;
        endcase
        if (hi_bits || (ldp && int'(pn) > NUM_PREG))
            legal = 1'b0;
        if (!legal) begin
            ldp     = 1'b0;
            pn      = 4'd0;
            is_str  = 1'b0;
            is_stop = 1'b0;
            fwe     = 1'b0;
            fsel    = 1'b0;
            b       = 3'd0;
            c       = 8'h00;
            alu     = 3'd0;
        end
    end

    always_comb begin
        data_write_en   = 1'b0;
        p_reg_write_en  = 1'b0;
        pc_en           = 1'b0;
        stop_flag       = 1'b0;
        flag_wr_en      = 1'b0;
        b_bus_select    = '0;
        c_bus_select    = '0;
        p_reg_select    = '0;
        alu_select      = 3'd0;
        flag_reg_select = '0;
        illegal_op      = 1'b0;
        busy            = (state == FETCH) || (state == EXEC) || (state == MEMWAIT);
        case (state)
            EXEC: begin
                data_write_en   = is_str;
                p_reg_write_en  = ldp;
                pc_en           = !(is_stop || (is_str && !mem_ready));
                stop_flag       = is_stop;
                flag_wr_en      = fwe;
                b_bus_select    = BSEL_W'(b);
                c_bus_select    = CSEL_W'(c);
                p_reg_select    = PSEL_W'(ldp ? pn - 4'd1 : 4'd0);
                alu_select      = alu;
                flag_reg_select = FSEL_W'(fsel);
                illegal_op      = !legal;
            end
            MEMWAIT: begin
                data_write_en = 1'b1;
                pc_en         = mem_ready;
            end
            HALT:    stop_flag = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ir    <= '0;
            fr    <= '0;
        end else begin
            case (state)
                IDLE, HALT: if (start) state <= FETCH;
                FETCH: if (instr_valid) begin
                    ir    <= opcode;
                    fr    <= flags;
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_stop)                   state <= HALT;
                    else if (is_str && !mem_ready) state <= MEMWAIT;
                    else                           state <= FETCH;
                end
                MEMWAIT: if (mem_ready) state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: opcode table plus hand sequences for memory wait, halt and reset.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, instr_valid, mem_ready;
    logic [5:0] opcode;
    logic [1:0] flags;

    logic       data_write_en, p_reg_write_en, pc_en, stop_flag, flag_wr_en, busy, illegal_op;
    logic [3:0] b_bus_select, p_reg_select;
    logic [7:0] c_bus_select;
    logic [2:0] alu_select;
    logic [0:0] flag_reg_select;

    logic       dwe4, pwe4, pc4, stop4, fwe4, busy4, ill4;
    logic [3:0] b4, ps4;
    logic [7:0] c4;
    logic [2:0] alu4;
    logic [0:0] fs4;

    control_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .instr_valid(instr_valid), .opcode(opcode),
        .flags(flags), .mem_ready(mem_ready), .data_write_en(data_write_en),
        .p_reg_write_en(p_reg_write_en), .pc_en(pc_en), .stop_flag(stop_flag),
        .flag_wr_en(flag_wr_en), .b_bus_select(b_bus_select), .c_bus_select(c_bus_select),
        .p_reg_select(p_reg_select), .alu_select(alu_select), .flag_reg_select(flag_reg_select),
        .busy(busy), .illegal_op(illegal_op)
    );

    control_sequencer #(.NUM_PREG(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .instr_valid(instr_valid), .opcode(opcode),
        .flags(flags), .mem_ready(mem_ready), .data_write_en(dwe4),
        .p_reg_write_en(pwe4), .pc_en(pc4), .stop_flag(stop4),
        .flag_wr_en(fwe4), .b_bus_select(b4), .c_bus_select(c4),
        .p_reg_select(ps4), .alu_select(alu4), .flag_reg_select(fs4),
        .busy(busy4), .illegal_op(ill4)
    );

    typedef logic [26:0] out_t;

    out_t act, act4;
    assign act  = {data_write_en, p_reg_write_en, p_reg_select, pc_en, stop_flag, flag_wr_en,
                   b_bus_select, c_bus_select, alu_select, flag_reg_select, illegal_op, busy};
    assign act4 = {dwe4, pwe4, ps4, pc4, stop4, fwe4, b4, c4, alu4, fs4, ill4, busy4};

    function automatic out_t mk(input logic dwe, input logic pwe, input logic [3:0] ps,
                                input logic pc, input logic stp, input logic fwe,
                                input logic [3:0] b, input logic [7:0] c, input logic [2:0] alu,
                                input logic fs, input logic ill, input logic bsy);
        return {dwe, pwe, ps, pc, stp, fwe, b, c, alu, fs, ill, bsy};
    endfunction

    typedef struct {
        logic [5:0] op;
        logic [1:0] fl;
        out_t       exp;
        string      name;
    } vec_t;

    vec_t vt[$];
    out_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    out_t zb, z0, ill_v;

    task automatic add(input logic [5:0] op, input logic [1:0] fl, input string name, input out_t e);
        vec_t v;
        v.op = op; v.fl = fl; v.exp = e; v.name = name;
        vt.push_back(v);
    endtask

    task automatic expect_out(input out_t v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string name, input bit use4);
        out_t a, e;
        a = use4 ? act4 : act;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: actual=%h but no expected value was queued", name, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", name, a, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        zb    = mk(0,0,4'd0,0,0,0,4'd0,8'h00,3'd0,0,0,1);
        z0    = mk(0,0,4'd0,0,0,0,4'd0,8'h00,3'd0,0,0,0);
        ill_v = mk(0,0,4'd0,1,0,0,4'd0,8'h00,3'd0,0,1,1);

        add(6'h01, 2'b00, "noop",   mk(0,0,4'd0,1,0,0,4'd0,8'h00,3'd0,0,0,1));
        add(6'h17, 2'b11, "write",  mk(0,0,4'd0,1,0,0,4'd0,8'h00,3'd0,0,0,1));
        add(6'h02, 2'b00, "ldp1",   mk(0,1,4'd0,1,0,0,4'd0,8'h00,3'd0,0,0,1));
        add(6'h05, 2'b00, "ldp4",   mk(0,1,4'd3,1,0,0,4'd0,8'h00,3'd0,0,0,1));
        add(6'h1D, 2'b00, "ldp9",   mk(0,1,4'd8,1,0,0,4'd0,8'h00,3'd0,0,0,1));
        add(6'h06, 2'b00, "cal",    mk(0,0,4'd0,1,0,0,4'd1,8'h02,3'd1,0,0,1));
        add(6'h07, 2'b00, "str_rdy",mk(1,0,4'd0,1,0,0,4'd0,8'h00,3'd0,0,0,1));
        add(6'h08, 2'b00, "pp2h",   mk(0,0,4'd0,1,0,0,4'd4,8'h01,3'd1,0,0,1));
        add(6'h09, 2'b00, "h2pp",   mk(0,0,4'd0,1,0,0,4'd0,8'h10,3'd0,0,0,1));
        add(6'h0A, 2'b00, "add",    mk(0,0,4'd0,1,0,0,4'd0,8'h01,3'd6,0,0,1));
        add(6'h0B, 2'b00, "sub",    mk(0,0,4'd0,1,0,0,4'd0,8'h01,3'd7,0,0,1));
        add(6'h0C, 2'b00, "ing1",   mk(0,0,4'd0,1,0,0,4'd7,8'h80,3'd5,0,0,1));
        add(6'h0D, 2'b00, "g2mar",  mk(0,0,4'd0,1,0,0,4'd7,8'h40,3'd1,0,0,1));
        add(6'h0E, 2'b00, "clh",    mk(0,0,4'd0,1,0,0,4'd0,8'h01,3'd2,0,0,1));
        add(6'h0F, 2'b00, "clx",    mk(0,0,4'd0,1,0,0,4'd0,8'h08,3'd2,0,0,1));
        add(6'h10, 2'b00, "cly",    mk(0,0,4'd0,1,0,0,4'd0,8'h04,3'd2,0,0,1));
        add(6'h11, 2'b00, "inx",    mk(0,0,4'd0,1,0,0,4'd5,8'h08,3'd5,0,0,1));
        add(6'h12, 2'b00, "iny",    mk(0,0,4'd0,1,0,0,4'd6,8'h04,3'd5,0,0,1));
        add(6'h13, 2'b01, "jumpx_t",mk(0,0,4'd0,1,0,0,4'd0,8'h20,3'd1,0,0,1));
        add(6'h13, 2'b00, "jumpx_f",mk(0,0,4'd0,1,0,0,4'd0,8'h00,3'd0,0,0,1));
        add(6'h14, 2'b10, "jumpy_t",mk(0,0,4'd0,1,0,0,4'd0,8'h20,3'd1,0,0,1));
        add(6'h14, 2'b01, "jumpy_f",mk(0,0,4'd0,1,0,0,4'd0,8'h00,3'd0,0,0,1));
        add(6'h15, 2'b00, "h2mar",  mk(0,0,4'd0,1,0,0,4'd0,8'h40,3'd0,0,0,1));
        add(6'h16, 2'b00, "pp2mar", mk(0,0,4'd0,1,0,0,4'd4,8'h40,3'd1,0,0,1));
        add(6'h1E, 2'b00, "setx",   mk(0,0,4'd0,1,0,1,4'd0,8'h00,3'd0,0,0,1));
        add(6'h1F, 2'b00, "sety",   mk(0,0,4'd0,1,0,1,4'd0,8'h00,3'd0,1,0,1));
        add(6'h00, 2'b00, "ill_00", ill_v);
        add(6'h20, 2'b00, "ill_20", ill_v);
        add(6'h3F, 2'b11, "ill_3f", ill_v);

        rst = 1'b1; start = 1'b0; instr_valid = 1'b0; mem_ready = 1'b1;
        opcode = 6'h00; flags = 2'b00;
        step(); step();
        rst = 1'b0;
        @(negedge clk); expect_out(z0); chk("reset_idle", 0);

        // Idle ignores instr_valid until start arrives.
        instr_valid = 1'b1; opcode = 6'h01;
        step(); @(negedge clk); expect_out(z0); chk("idle_no_start", 0);
        instr_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;

        foreach (vt[i]) begin
            opcode = vt[i].op; flags = vt[i].fl; instr_valid = 1'b1; mem_ready = 1'b1;
            @(negedge clk); expect_out(zb); chk({"fetch_", vt[i].name}, 0);
            step();
            instr_valid = 1'b0; flags = ~vt[i].fl;
            @(negedge clk); expect_out(vt[i].exp); chk(vt[i].name, 0);
            step();
        end

        // LDP9 against a 4-register instance is illegal.
        opcode = 6'h1D; flags = 2'b00; instr_valid = 1'b1;
        step(); instr_valid = 1'b0;
        @(negedge clk);
        expect_out(mk(0,1,4'd8,1,0,0,4'd0,8'h00,3'd0,0,0,1)); chk("ldp9_full", 0);
        expect_out(ill_v); chk("ldp9_npreg4", 1);
        step();
        @(negedge clk); expect_out(zb); chk("ill_pulse_end", 1);

        // STR with memory stalled for three cycles.
        opcode = 6'h07; instr_valid = 1'b1; mem_ready = 1'b0;
        step(); instr_valid = 1'b0;
        @(negedge clk); expect_out(mk(1,0,4'd0,0,0,0,4'd0,8'h00,3'd0,0,0,1)); chk("str_exec_wait", 0);
        step();
        @(negedge clk); expect_out(mk(1,0,4'd0,0,0,0,4'd0,8'h00,3'd0,0,0,1)); chk("str_mw1", 0);
        step();
        @(negedge clk); expect_out(mk(1,0,4'd0,0,0,0,4'd0,8'h00,3'd0,0,0,1)); chk("str_mw2", 0);
        step(); mem_ready = 1'b1;
        @(negedge clk); expect_out(mk(1,0,4'd0,1,0,0,4'd0,8'h00,3'd0,0,0,1)); chk("str_mw_done", 0);
        step();
        @(negedge clk); expect_out(zb); chk("str_back_fetch", 0);

        // Reset during the second MEMWAIT cycle.
        opcode = 6'h07; instr_valid = 1'b1; mem_ready = 1'b0;
        step(); instr_valid = 1'b0;
        step();
        step(); rst = 1'b1;
        @(negedge clk); expect_out(mk(1,0,4'd0,0,0,0,4'd0,8'h00,3'd0,0,0,1)); chk("mw2_before_rst", 0);
        step(); rst = 1'b0;
        @(negedge clk); expect_out(z0); chk("rst_from_mw", 0);
        mem_ready = 1'b1; instr_valid = 1'b1; opcode = 6'h01;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk); expect_out(z0); chk("post_rst_no_start", 0);
        end
        instr_valid = 1'b0;

        // STOP then hold in HALT, then restart.
        start = 1'b1; step(); start = 1'b0;
        opcode = 6'h18; instr_valid = 1'b1;
        step(); instr_valid = 1'b0;
        @(negedge clk); expect_out(mk(0,0,4'd0,0,1,0,4'd0,8'h00,3'd0,0,0,1)); chk("stop_exec", 0);
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clk); expect_out(mk(0,0,4'd0,0,1,0,4'd0,8'h00,3'd0,0,0,0)); chk("halt_hold", 0);
        end
        start = 1'b1; step(); start = 1'b0;
        @(negedge clk); expect_out(zb); chk("halt_restart", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
